// File: rtl/ir_pkg.sv
// Shared definitions for the NEC IR key controller: frame byte layout,
// FSM encodings and the queued key-event format.
package ir_pkg;

   localparam int FRM_ADDR_LSB  = 24;
   localparam int FRM_NADDR_LSB = 16;
   localparam int FRM_CMD_LSB   = 8;
   localparam int FRM_NCMD_LSB  = 0;

   localparam int KEY_EVT_W = 9;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      PRESSED = 2'd1,
      HELD    = 2'd2
   } ir_state_e;

   typedef struct packed {
      logic       rpt;
      logic [7:0] cmd;
   } key_evt_t;

   function automatic logic [7:0] frm_byte(input logic [31:0] frame, input int lsb);
      return frame[lsb +: 8];
   endfunction

endpackage

// File: rtl/ir_evt_fifo.sv
// Small synchronous FIFO with a registered head entry; the head holds its
// last value once the FIFO drains.
module ir_evt_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 9
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [WIDTH-1:0] din,
   input  logic             pop,
   output logic             full,
   output logic             empty,
   output logic             vld,
   output logic [WIDTH-1:0] dout
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr, rd_ptr, rd_ptr_n;
   logic [AW:0]      count, count_n, remain;
   logic             do_push, do_pop;

   assign empty   = (count == '0);
   assign full    = (count == FULL_CNT);
   assign do_pop  = pop & ~empty;
   assign do_push = push & (~full | do_pop);

   assign rd_ptr_n = do_pop ? rd_ptr + 1'b1 : rd_ptr;
   assign remain   = count - {{AW{1'b0}}, do_pop};

   always_comb begin
      count_n = count;
      if (do_push && !do_pop)
         count_n = count + 1'b1;
      else if (!do_push && do_pop)
         count_n = count - 1'b1;
   end

   always_ff @(posedge clk) begin
      if (do_push)
         mem[wr_ptr] <= din;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         vld    <= 1'b0;
         dout   <= '0;
      end else begin
         if (do_push)
            wr_ptr <= wr_ptr + 1'b1;
         rd_ptr <= rd_ptr_n;
         count  <= count_n;
         vld    <= (count_n != '0);
         // Nothing left behind the popped head: the new head is this cycle's push.
         if (count_n != '0)
            dout <= (remain == '0) ? din : mem[rd_ptr_n];
      end
   end

endmodule

// File: rtl/ir_key_ctrl.sv
// NEC IR key-event controller: frame validation, press/hold tracking with
// repeat codes and release timeout, events queued towards the consumer.
//   state   | meaning
//   IDLE    | no key down; orphan repeat codes ignored
//   PRESSED | key down, counting repeats up to the auto-repeat delay
//   HELD    | auto-repeating, one event per RPT_RATE repeat codes
module ir_key_ctrl
   import ir_pkg::*;
#(
   parameter logic [7:0]  ADDR     = 8'h00,
   parameter int unsigned RPT_TMO  = 6_000_000,
   parameter int unsigned RPT_DLY  = 3,
   parameter int unsigned RPT_RATE = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] i_frame,
   input  logic        i_frame_vld,
   input  logic        i_rpt_vld,
   output logic        o_key_vld,
   input  logic        i_key_rdy,
   output logic [7:0]  o_key,
   output logic        o_key_rpt,
   output logic        o_held,
   output logic [7:0]  o_err_cnt,
   output logic [7:0]  o_drop_cnt
);

   localparam logic [22:0] TMR_LAST = 23'(RPT_TMO - 1);
   localparam logic [3:0]  DLY_C    = 4'(RPT_DLY);
   localparam logic [3:0]  RATE_C   = 4'(RPT_RATE);

   ir_state_e   state, state_n;
   logic [22:0] timer, timer_n;
   logic [3:0]  rpt_cnt, rpt_cnt_n, rpt_lim;
   logic [7:0]  last_cmd, last_cmd_n, cmd;
   logic        frame_good, push, pop, err_inc, drop;
   logic        fifo_full, fifo_empty;
   key_evt_t    push_evt, head;

   assign cmd = frm_byte(i_frame, FRM_CMD_LSB);
   assign frame_good =
      (frm_byte(i_frame, FRM_ADDR_LSB) == ADDR) &&
      ((frm_byte(i_frame, FRM_ADDR_LSB) ^ frm_byte(i_frame, FRM_NADDR_LSB)) == 8'hFF) &&
      ((cmd ^ frm_byte(i_frame, FRM_NCMD_LSB)) == 8'hFF);

   assign rpt_lim = (state == HELD) ? RATE_C : DLY_C;

   always_comb begin
      state_n    = state;
      timer_n    = timer;
      rpt_cnt_n  = rpt_cnt;
      last_cmd_n = last_cmd;
      push       = 1'b0;
      push_evt   = '{rpt: 1'b0, cmd: cmd};
      err_inc    = 1'b0;
      if (i_frame_vld) begin
         // A simultaneous repeat strobe is deliberately dropped here.
         if (frame_good) begin
            push       = 1'b1;
            last_cmd_n = cmd;
            rpt_cnt_n  = '0;
            timer_n    = '0;
            state_n    = PRESSED;
         end else begin
            err_inc = 1'b1;
         end
      end else begin
         case (state)
            IDLE: ;
            PRESSED, HELD: begin
               if (i_rpt_vld) begin
                  timer_n = '0;
                  if (rpt_cnt + 4'd1 == rpt_lim) begin
                     push      = 1'b1;
                     push_evt  = '{rpt: 1'b1, cmd: last_cmd};
                     rpt_cnt_n = '0;
                     state_n   = HELD;
                  end else begin
                     rpt_cnt_n = rpt_cnt + 4'd1;
                  end
               end else if (timer == TMR_LAST) begin
                  state_n   = IDLE;
                  rpt_cnt_n = '0;
                  timer_n   = '0;
               end else begin
                  timer_n = timer + 23'd1;
               end
            end
            default: state_n = IDLE;
         endcase
      end
   end

   assign pop  = i_key_rdy & ~fifo_empty;
   assign drop = push & fifo_full & ~pop;

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         timer      <= '0;
         rpt_cnt    <= '0;
         last_cmd   <= '0;
         o_err_cnt  <= '0;
         o_drop_cnt <= '0;
      end else begin
         state    <= state_n;
         timer    <= timer_n;
         rpt_cnt  <= rpt_cnt_n;
         last_cmd <= last_cmd_n;
         if (err_inc && o_err_cnt != 8'hFF)
            o_err_cnt <= o_err_cnt + 8'd1;
         if (drop && o_drop_cnt != 8'hFF)
            o_drop_cnt <= o_drop_cnt + 8'd1;
      end
   end

   ir_evt_fifo #(.DEPTH(4), .WIDTH(KEY_EVT_W)) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push),
      .din   (push_evt),
      .pop   (pop),
      .full  (fifo_full),
      .empty (fifo_empty),
      .vld   (o_key_vld),
      .dout  (head)
   );

   assign o_key     = head.cmd;
   assign o_key_rpt = head.rpt;
   assign o_held    = (state != IDLE);

endmodule

// File: tb/tb_ir_key_ctrl.sv
// Scoreboard bench for ir_key_ctrl with a short release timeout.
module tb_ir_key_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] i_frame;
   logic        i_frame_vld, i_rpt_vld, i_key_rdy;
   logic        o_key_vld, o_key_rpt, o_held;
   logic [7:0]  o_key, o_err_cnt, o_drop_cnt;

   int n_checks = 0;
   int n_errors = 0;
   logic [8:0] exp_q[$];

   always #5 clk = ~clk;

   ir_key_ctrl #(.ADDR(8'h00), .RPT_TMO(200), .RPT_DLY(2), .RPT_RATE(1)) dut (
      .clk         (clk),
      .rst         (rst),
      .i_frame     (i_frame),
      .i_frame_vld (i_frame_vld),
      .i_rpt_vld   (i_rpt_vld),
      .o_key_vld   (o_key_vld),
      .i_key_rdy   (i_key_rdy),
      .o_key       (o_key),
      .o_key_rpt   (o_key_rpt),
      .o_held      (o_held),
      .o_err_cnt   (o_err_cnt),
      .o_drop_cnt  (o_drop_cnt)
   );

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] mk_frame(input logic [7:0] a, input logic [7:0] c);
      return {a, ~a, c, ~c};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic send_frame(input logic [31:0] f, input bit expect_evt);
      i_frame     = f;
      i_frame_vld = 1'b1;
      if (expect_evt) exp_q.push_back({1'b0, f[15:8]});
      tick();
      i_frame_vld = 1'b0;
   endtask

   task automatic send_rpt(input bit expect_evt, input logic [7:0] c);
      i_rpt_vld = 1'b1;
      if (expect_evt) exp_q.push_back({1'b1, c});
      tick();
      i_rpt_vld = 1'b0;
   endtask

   task automatic wait_idle();
      int cyc = 0;
      while (o_held && cyc < 300) begin
         tick();
         cyc++;
      end
      check_val("release_timeout", o_held, 0);
   endtask

   // Consumer side: any entry taken by the next edge must match the scoreboard head.
   always @(negedge clk) begin
      logic [8:0] e;
      if (!rst && o_key_vld && i_key_rdy) begin
         check_val("evt_expected", exp_q.size() != 0, 1);
         if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check_val("evt", {o_key_rpt, o_key}, e);
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout, want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; i_frame = '0; i_frame_vld = 1'b0; i_rpt_vld = 1'b0; i_key_rdy = 1'b1;
      idle(3);
      rst = 1'b0;
      tick();
      check_val("rst_vld",  o_key_vld, 0);
      check_val("rst_key",  {o_key_rpt, o_key}, 0);
      check_val("rst_held", o_held, 0);
      check_val("rst_err",  o_err_cnt, 0);
      check_val("rst_drop", o_drop_cnt, 0);

      // 1: single press, exact release timing
      send_frame(32'h00FF_45BA, 1);
      check_val("t1_vld",  o_key_vld, 1);
      check_val("t1_head", {o_key_rpt, o_key}, 9'h045);
      check_val("t1_held", o_held, 1);
      idle(199);
      check_val("t1_held_pre_tmo", o_held, 1);
      tick();
      check_val("t1_released", o_held, 0);

      // 2: rejected frames
      send_frame(32'h00FF_45BB, 0);
      send_frame(32'h01FE_45BA, 0);
      idle(2);
      check_val("t2_err",  o_err_cnt, 2);
      check_val("t2_held", o_held, 0);
      check_val("t2_vld",  o_key_vld, 0);

      // 3: press then hold with repeat codes
      send_frame(mk_frame(8'h00, 8'h18), 1);
      for (int r = 1; r <= 4; r++) begin
         idle(99);
         send_rpt(r >= 2, 8'h18);
      end
      idle(2);
      check_val("t3_held", o_held, 1);
      wait_idle();
      check_val("t3_q_drained", exp_q.size(), 0);

      // 4: FIFO overflow with stalled consumer
      i_key_rdy = 1'b0;
      for (int k = 1; k <= 6; k++) send_frame(mk_frame(8'h00, 8'(k)), k <= 4);
      check_val("t4_drop", o_drop_cnt, 2);
      check_val("t4_head_stable", {o_key_vld, o_key}, 9'h101);
      i_key_rdy = 1'b1;
      idle(4);
      check_val("t4_empty_after_4", o_key_vld, 0);
      check_val("t4_key_hold", o_key, 8'h04);
      check_val("t4_q_drained", exp_q.size(), 0);

      // 5: full FIFO, push and pop in the same cycle
      i_key_rdy = 1'b0;
      for (int k = 7; k <= 10; k++) send_frame(mk_frame(8'h00, 8'(k)), 1);
      i_key_rdy = 1'b1;
      send_frame(mk_frame(8'h00, 8'h0B), 1);
      i_key_rdy = 1'b0;
      check_val("t5_drop", o_drop_cnt, 2);
      check_val("t5_head", {o_key_vld, o_key}, 9'h108);
      i_key_rdy = 1'b1;
      idle(4);
      check_val("t5_empty", o_key_vld, 0);
      check_val("t5_last", o_key, 8'h0B);
      check_val("t5_q_drained", exp_q.size(), 0);
      wait_idle();

      // 6: orphan repeat, frame+repeat collision, reset mid-hold
      send_rpt(0, 8'h00);
      idle(2);
      check_val("t6_orphan_held", o_held, 0);
      check_val("t6_orphan_vld", o_key_vld, 0);
      i_rpt_vld = 1'b1;
      send_frame(mk_frame(8'h00, 8'h22), 1);
      i_rpt_vld = 1'b0;
      check_val("t6_coll_held", o_held, 1);
      idle(10);
      send_rpt(0, 8'h22);
      idle(10);
      send_rpt(1, 8'h22);
      idle(3);
      i_key_rdy = 1'b0;
      send_rpt(1, 8'h22);
      check_val("t6_pending", o_key_vld, 1);
      rst = 1'b1;
      i_frame = mk_frame(8'h00, 8'h33);
      i_frame_vld = 1'b1;
      tick();
      rst = 1'b0;
      i_frame_vld = 1'b0;
      exp_q.delete();
      check_val("t6_rst_vld",  o_key_vld, 0);
      check_val("t6_rst_held", o_held, 0);
      check_val("t6_rst_cnts", {o_err_cnt, o_drop_cnt}, 0);
      idle(2);
      check_val("t6_rst_strobe_lost", {o_key_vld, o_held}, 0);
      i_key_rdy = 1'b1;
      idle(2);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
